viterbi_traceback: RTL and testbench
====================================

# viterbi_traceback

Radix-4 Viterbi survivor-path traceback stage, directly downstream of `add_compare_select`. Each step it stores one column of 256 survivor predecessor states from the ACS. When a frame completes, it walks the stored trellis backwards from the selected end node. It then emits the decoded bits, two per trellis step, as one parallel word with a valid pulse.

## Interface
- `NUM_ST`, 256: trellis states. Must be a power of 2.
- `ST_W`, 8: state width, log2(NUM_ST).
- `TB_DEPTH`, 16: maximum radix-4 steps per frame. Output word width is 2*TB_DEPTH.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en_t`  in  1  survivor column valid.
- `i_prv_st`  in  [ST_W-1:0] x [NUM_ST-1:0]  for each current state s, the predecessor selected by ACS.
- `i_sel_node`  in  ST_W  minimum-metric end state. Sampled only with the frame-closing column.
- `i_last`  in  1  qualifies `en_t`; this column closes a short frame.
- `o_ready`  out  1  a column is accepted on `en_t && o_ready`.
- `o_valid`  out  1  one-cycle pulse; `o_data`/`o_nsteps` are valid.
- `o_data`  out  2*TB_DEPTH  decoded pairs; step k occupies [2k+1:2k].
- `o_nsteps`  out  clog2(TB_DEPTH)+1  number of steps in the frame (1..TB_DEPTH).

## Operation
- Survivor memory: `mem[TB_DEPTH][NUM_ST]` of ST_W bits. It is not reset.
- Write counter `wr_cnt`: 0..TB_DEPTH-1.
- FSM states: FILL, TRACE, DONE. Reset enters FILL with `wr_cnt`=0.
- FILL:
  - `o_ready`=1.
  - On accept: write `mem[wr_cnt][s] <= i_prv_st[s]` for all s.
  - If `wr_cnt`==TB_DEPTH-1 or `i_last`:
    - latch `st <= i_sel_node`;
    - set `rd_idx <= wr_cnt` and `nsteps <= wr_cnt+1`;
    - go to TRACE.
  - Otherwise `wr_cnt++`.
- TRACE:
  - `o_ready`=0.
  - Each cycle: `dec[rd_idx] <= st[1:0]` (newest input pair sits in the state LSBs), then `st <= mem[rd_idx][st]`.
  - If `rd_idx`==0, go to DONE; otherwise `rd_idx--`.
- DONE:
  - `o_valid`=1 for exactly one cycle.
  - `o_data` = the `dec` register; pairs at steps ≥ `nsteps` are 0.
  - `o_nsteps` = `nsteps`.
  - Clear `dec` and `wr_cnt`, then go to FILL.
- `en_t` while `o_ready`=0 is ignored. Memory and counters are unchanged, and no error is flagged.
- `i_last` without `en_t` is ignored.
- `i_last` on column TB_DEPTH-1 behaves identically to a full frame.

## Timing
- Reset values: `o_ready`=0 while `rst`=1, `o_valid`=0, `o_data`=0, `o_nsteps`=0.
- First cycle after reset release: `o_ready`=1.
- Frame-closing column accepted at edge T:
  - TRACE occupies cycles T+1..T+n, where n = `nsteps`;
  - `o_valid`=1 during cycle T+n+1;
  - `o_ready` returns to 1 at cycle T+n+2.
- Worst-case latency is TB_DEPTH+1 cycles.
- Maximum throughput is one frame per 2*TB_DEPTH+1 cycles.
- `o_data`/`o_nsteps` hold their values after the pulse until the next DONE.
- `rst` mid-TRACE or in DONE:
  - next cycle is FILL with `wr_cnt`=0;
  - pending output is discarded and no `o_valid` is produced;
  - `o_data`/`o_nsteps` return to 0.
- `st` and the memory read are a combinational index within one cycle. There is no read-latency pipeline.

## Configuration
- `TB_ZERO_START_EN` defined: the trellis is terminated. Traceback starts from state 0, and `i_sel_node` is ignored (the port remains present).
- Not defined: traceback starts from the `i_sel_node` value latched with the closing column.

## Test plan
- Reset and idle:
  - hold `rst`=1 for 3 cycles -> `o_ready`=0, `o_valid`=0, `o_data`=0;
  - after release -> `o_ready`=1 the next cycle.
- Identity survivors, full frame:
  - stimulus: `i_prv_st[s]`=s for 16 columns, `i_sel_node`=8'hA5 with column 15;
  - response: `o_valid` exactly 17 cycles after the last accept, `o_data`=32'h5555_5555, `o_nsteps`=16.
- Shift-register survivors:
  - stimulus: `i_prv_st[s]`={2'b00,s[7:2]} for 16 columns, `i_sel_node`=8'hE4;
  - response: `o_data`=32'h1B00_0000.
- Short frame:
  - stimulus: identity survivors, `i_last` on the 4th column, `i_sel_node`=8'h03;
  - response: `o_nsteps`=4, `o_data`=32'h0000_00FF, `o_valid` 5 cycles after the 4th accept.
- Backpressure and reset:
  - `en_t` held high with changed `i_prv_st` during TRACE -> columns are not written and the decoded result is unchanged;
  - `rst` pulsed mid-TRACE -> no `o_valid`, and the next frame decodes correctly.
- With `TB_ZERO_START_EN` defined:
  - stimulus: identity survivors, `i_sel_node`=8'hFF;
  - response: `o_data`=32'h0000_0000.

Source files
------------

// File: rtl/viterbi_traceback.sv
// rtl/viterbi_traceback.sv - radix-4 Viterbi survivor-path traceback stage.
// Define TB_ZERO_START_EN for terminated trellises (traceback always starts from state 0).
module viterbi_traceback #(
  parameter int NUM_ST   = 256,
  parameter int ST_W     = 8,
  parameter int TB_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en_t,
  input  logic [NUM_ST-1:0][ST_W-1:0]       i_prv_st,
  input  logic [ST_W-1:0]                   i_sel_node,
  input  logic                              i_last,
  output logic                              o_ready,
  output logic                              o_valid,
  output logic [2*TB_DEPTH-1:0]             o_data,
  output logic [$clog2(TB_DEPTH):0]         o_nsteps
);

  localparam int CW = $clog2(TB_DEPTH);

  // Masking the selected node keeps one code path for both start-state policies.
`ifdef TB_ZERO_START_EN
  localparam logic [ST_W-1:0] START_MASK = '0;
`else
  localparam logic [ST_W-1:0] START_MASK = '1;
`endif

  typedef enum logic [1:0] {FILL, TRACE, DONE} state_t;

  state_t                        state_q;
  logic [CW-1:0]                 wr_cnt_q;
  logic [CW-1:0]                 rd_idx_q;
  logic [CW:0]                   nsteps_q;
  logic [ST_W-1:0]               st_q;
  logic [2*TB_DEPTH-1:0]         dec_q;
  logic [2*TB_DEPTH-1:0]         dec_d;
  logic                          ready_q;
  logic                          valid_q;
  logic [2*TB_DEPTH-1:0]         data_q;
  logic [CW:0]                   nsteps_out_q;

  logic [NUM_ST-1:0][ST_W-1:0]   mem [TB_DEPTH];

  logic                          accept;
  logic                          closing;
  logic [ST_W-1:0]               surv;

  assign accept  = en_t && ready_q && (state_q == FILL);
  assign closing = accept && ((wr_cnt_q == CW'(TB_DEPTH - 1)) || i_last);
  assign surv    = mem[rd_idx_q][st_q];

  // The newest input pair of each step sits in the two LSBs of the state.
  always_comb begin
    dec_d = dec_q;
    dec_d[{rd_idx_q, 1'b0} +: 2] = st_q[1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[wr_cnt_q] <= i_prv_st;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      wr_cnt_q     <= '0;
      rd_idx_q     <= '0;
      nsteps_q     <= '0;
      st_q         <= '0;
      dec_q        <= '0;
      ready_q      <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      nsteps_out_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          if (closing) begin
            st_q     <= i_sel_node & START_MASK;
            rd_idx_q <= wr_cnt_q;
            nsteps_q <= {1'b0, wr_cnt_q} + (CW+1)'(1);
            ready_q  <= 1'b0;
            state_q  <= TRACE;
          end else if (accept) begin
            wr_cnt_q <= wr_cnt_q + CW'(1);
          end
        end
        TRACE: begin
          dec_q <= dec_d;
          st_q  <= surv;
          if (rd_idx_q == '0) begin
            valid_q      <= 1'b1;
            data_q       <= dec_d;
            nsteps_out_q <= nsteps_q;
            state_q      <= DONE;
          end else begin
            rd_idx_q <= rd_idx_q - CW'(1);
          end
        end
        DONE: begin
          valid_q  <= 1'b0;
          dec_q    <= '0;
          wr_cnt_q <= '0;
          ready_q  <= 1'b1;
          state_q  <= FILL;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b0;
          state_q <= FILL;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign o_nsteps = nsteps_out_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb/tb_viterbi_traceback.sv - randomized scoreboard bench for viterbi_traceback.
// Stimulus pushes model results; a negedge monitor pops and compares on o_valid.
module tb_viterbi_traceback;
  localparam int NUM_ST   = 256;
  localparam int ST_W     = 8;
  localparam int TB_DEPTH = 16;

  typedef logic [NUM_ST-1:0][ST_W-1:0] col_t;
  typedef struct {
    logic [2*TB_DEPTH-1:0] d;
    logic [4:0]            n;
    int                    cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en_t;
  col_t                  i_prv_st;
  logic [ST_W-1:0]       i_sel_node;
  logic                  i_last;
  logic                  o_ready;
  logic                  o_valid;
  logic [2*TB_DEPTH-1:0] o_data;
  logic [4:0]            o_nsteps;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  logic [2*TB_DEPTH-1:0] last_d;

  viterbi_traceback #(.NUM_ST(NUM_ST), .ST_W(ST_W), .TB_DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst(rst), .en_t(en_t), .i_prv_st(i_prv_st),
    .i_sel_node(i_sel_node), .i_last(i_last), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .o_nsteps(o_nsteps)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d expected 0", cyc);
      end else begin
        e = sb.pop_front();
        check("data", o_data, e.d);
        check("nsteps", o_nsteps, e.n);
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Reference: walk the stored columns backwards, emitting the state's low pair per step.
  function automatic logic [2*TB_DEPTH-1:0] ref_trace(input col_t cols[TB_DEPTH], input int n,
                                                      input logic [ST_W-1:0] sel);
    logic [ST_W-1:0]       s;
    logic [2*TB_DEPTH-1:0] r;
    r = '0;
`ifdef TB_ZERO_START_EN
    s = '0;
`else
    s = sel;
`endif
    for (int k = n - 1; k >= 0; k--) begin
      r[2*k +: 2] = s[1:0];
      s = cols[k][s];
    end
    return r;
  endfunction

  task automatic send_col(input col_t col, input logic last, input logic [ST_W-1:0] sel,
                          output int acc);
    int w;
    en_t = 1'b1;
    i_prv_st = col;
    i_last = last;
    i_sel_node = sel;
    w = 0;
    while (o_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (o_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got o_ready=%b expected 1", o_ready);
    end
    @(negedge clk);
    acc = cyc;
  endtask

  // mode: 0 identity, 1 shift-register, 2 random. extra: 0 none, 1 backpressure, 2 reset mid-trace.
  task automatic run_frame(input int mode, input int n, input logic use_last,
                           input logic [ST_W-1:0] sel, input int extra);
    col_t cols[TB_DEPTH];
    int   acc;
    exp_t e;
    for (int k = 0; k < TB_DEPTH; k++) begin
      for (int s = 0; s < NUM_ST; s++) begin
        case (mode)
          0:       cols[k][s] = ST_W'(s);
          1:       cols[k][s] = ST_W'(s >> 2);
          default: cols[k][s] = ST_W'($urandom);
        endcase
      end
    end
    for (int k = 0; k < n; k++) begin
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        en_t = 1'b0;
        i_last = 1'b1;
        i_sel_node = ST_W'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_col(cols[k], (k == n - 1) ? use_last : 1'b0,
               (k == n - 1) ? sel : ST_W'($urandom), acc);
    end
    if (extra == 2) begin
      en_t = 1'b0;
      i_last = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", o_ready, 0);
      check("rst_data", o_data, 0);
      check("rst_nsteps", o_nsteps, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_ready", o_ready, 1);
    end else begin
      e.d = ref_trace(cols, n, sel);
      e.n = 5'(n);
      e.cyc = acc + n;
      last_d = e.d;
      sb.push_back(e);
      if (extra == 1) begin
        for (int k = 0; k < n; k++) begin
          for (int s = 0; s < NUM_ST; s++) i_prv_st[s] = ST_W'($urandom);
          i_last = 1'($urandom);
          i_sel_node = ST_W'($urandom);
          @(negedge clk);
        end
      end
      en_t = 1'b0;
      i_last = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int w;
    logic ul;
    rst = 1'b1;
    en_t = 1'b0;
    i_last = 1'b0;
    i_prv_st = '0;
    i_sel_node = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset_ready", o_ready, 0);
      check("reset_valid", o_valid, 0);
      check("reset_data", o_data, 0);
      check("reset_nsteps", o_nsteps, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("release_ready", o_ready, 1);

    run_frame(0, 16, 1'b0, 8'hA5, 0);
    run_frame(1, 16, 1'b0, 8'hE4, 0);
    run_frame(0, 4, 1'b1, 8'h03, 0);
    run_frame(2, 16, 1'b1, ST_W'($urandom), 0);
    run_frame(2, 10, 1'b1, ST_W'($urandom), 1);
    run_frame(2, 16, 1'b0, ST_W'($urandom), 2);
    run_frame(0, 16, 1'b0, 8'hA5, 0);
    run_frame(1, 1, 1'b1, 8'h7E, 0);
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, TB_DEPTH);
      ul = (n < TB_DEPTH) ? 1'b1 : 1'($urandom);
      run_frame(2, n, ul, ST_W'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    w = 0;
    while (sb.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", sb.size(), 0);
    repeat (5) @(negedge clk);
    check("hold_data", o_data, last_d);
    check("idle_valid", o_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
